// File: rtl/ram_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_ctrl_pkg
// Purpose  : Shared types and helpers for the state-RAM port arbiter.
//            - lock_state_e : ownership state of the round-robin arbiter
//            - idx_width()  : width of a requester index for R requesters
//            - field_lsb()  : LSB position of one requester's slice in a
//                             packed per-requester bus
// Revision : 1.0 - initial release
// ============================================================================
package ram_ctrl_pkg;

  typedef enum logic [0:0] {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Index width for r requesters; never narrower than one bit.
  function automatic int idx_width(input int r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

  localparam int R_DEFAULT = 4;
  localparam int IDXW      = idx_width(R_DEFAULT);

  // Packed per-requester buses place requester idx at [idx*width +: width].
  function automatic int field_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_rr_arbiter
// Purpose  : Round-robin winner selection with a per-requester lock.
//            Holds the rotation pointer and the lock ownership FSM.
// Ports    : Clk, Rst        clock, synchronous active-high reset
//            req[R]          requests (held until granted)
//            lock[R]         keep ownership after the current grant
//            gnt[R]          one-hot grant, combinational
//            gnt_valid       a winner exists this cycle
//            gnt_idx         index of the winner
// Revision : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter  int R  = 4,
  localparam int IW = idx_width(R)
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [R-1:0]  req,
  input  logic [R-1:0]  lock,
  output logic [R-1:0]  gnt,
  output logic          gnt_valid,
  output logic [IW-1:0] gnt_idx
);

  lock_state_e   r_state;
  lock_state_e   w_state_nxt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] w_owner_nxt;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] w_ptr_nxt;
  logic [IW:0]   w_cand;
  logic          w_valid;
  logic [IW-1:0] w_idx;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state <= UNLOCKED;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_valid     = 1'b0;
    w_idx       = '0;
    w_cand      = '0;
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    gnt         = '0;

    if (!Rst) begin
      if (r_state == LOCKED) begin
        if (req[r_owner]) begin
          w_valid = 1'b1;
          w_idx   = r_owner;
        end
      end else begin
        // Walk from the farthest offset back to the pointer so that the
        // candidate closest to ptr is the last (and winning) assignment.
        for (int i = R - 1; i >= 0; i--) begin
          w_cand = {1'b0, r_ptr} + (IW+1)'(i);
          if (w_cand >= (IW+1)'(R)) begin
            w_cand = w_cand - (IW+1)'(R);
          end
          if (req[w_cand[IW-1:0]]) begin
            w_valid = 1'b1;
            w_idx   = w_cand[IW-1:0];
          end
        end
      end
    end

    if (w_valid) begin
      gnt[w_idx] = 1'b1;
      w_ptr_nxt  = (w_idx == IW'(R - 1)) ? '0 : w_idx + IW'(1);
    end

    case (r_state)
      UNLOCKED: begin
        if (w_valid && lock[w_idx]) begin
          w_state_nxt = LOCKED;
          w_owner_nxt = w_idx;
        end
      end
      LOCKED: begin
        // Owner either dropped its request (nothing granted this cycle)
        // or was granted with lock deasserted: release in both cases.
        if (!req[r_owner] || !lock[r_owner]) begin
          w_state_nxt = UNLOCKED;
        end
      end
      default: w_state_nxt = UNLOCKED;
    endcase
  end

  assign gnt_valid = w_valid;
  assign gnt_idx   = w_idx;

endmodule
`default_nettype wire

// File: rtl/ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_port_arbiter
// Purpose  : Shares a dual-read / single-write state RAM between R
//            requesters. One granted access per cycle: two operand reads
//            plus an optional write to the first operand address. Read data
//            is registered back to the winner one cycle later.
// Ports    : Clk, Rst                 clock, synchronous active-high reset
//            req/we/lock[R]           per-requester control
//            addr_a/addr_b/wdata      packed per-requester fields
//            gnt[R]                   one-hot combinational grant
//            rvalid/rid/rdata_a/b     registered response
//            rerr                     response had an out-of-range address
//            ram_*                    RAM port drive / combinational read data
// Revision : 1.0 - initial release
// ============================================================================
module ram_port_arbiter
  import ram_ctrl_pkg::*;
#(
  parameter  int N  = 16,
  parameter  int M  = 6000,
  parameter  int K  = 13,
  parameter  int R  = 4,
  localparam int IW = idx_width(R)
) (
  input  logic           Clk,
  input  logic           Rst,
  input  logic [R-1:0]   req,
  input  logic [R-1:0]   we,
  input  logic [R-1:0]   lock,
  input  logic [R*K-1:0] addr_a,
  input  logic [R*K-1:0] addr_b,
  input  logic [R*N-1:0] wdata,
  output logic [R-1:0]   gnt,
  output logic           rvalid,
  output logic [IW-1:0]  rid,
  output logic [N-1:0]   rdata_a,
  output logic [N-1:0]   rdata_b,
  output logic           rerr,
  output logic [K-1:0]   ram_addr_one,
  output logic [K-1:0]   ram_addr_two,
  output logic [K-1:0]   ram_addr_wr,
  output logic           ram_we,
  output logic [N-1:0]   ram_wdata,
  input  logic [N-1:0]   ram_rdata_one,
  input  logic [N-1:0]   ram_rdata_two
);

  logic          w_gnt_valid;
  logic [IW-1:0] w_gnt_idx;
  logic [K-1:0]  w_addr_a;
  logic [K-1:0]  w_addr_b;
  logic [N-1:0]  w_wdata;
  logic          w_we;
  logic          w_oor;

  logic          r_rvalid;
  logic [IW-1:0] r_rid;
  logic [N-1:0]  r_rdata_a;
  logic [N-1:0]  r_rdata_b;
  logic          r_rerr;

  ram_rr_arbiter #(
    .R (R)
  ) u_arb (
    .Clk       (Clk),
    .Rst       (Rst),
    .req       (req),
    .lock      (lock),
    .gnt       (gnt),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  // Winner's fields; everything reads as zero when nobody is granted.
  always_comb begin
    w_addr_a = '0;
    w_addr_b = '0;
    w_wdata  = '0;
    w_we     = 1'b0;
    if (w_gnt_valid) begin
      w_addr_a = addr_a[field_lsb(32'(w_gnt_idx), K) +: K];
      w_addr_b = addr_b[field_lsb(32'(w_gnt_idx), K) +: K];
      w_wdata  = wdata[field_lsb(32'(w_gnt_idx), N) +: N];
      w_we     = we[w_gnt_idx];
    end
  end

  // Either operand outside the populated depth poisons the whole access.
  assign w_oor = (32'(w_addr_a) >= 32'(M)) || (32'(w_addr_b) >= 32'(M));

  assign ram_addr_one = w_addr_a;
  assign ram_addr_wr  = w_addr_a;
  assign ram_addr_two = w_addr_b;
  assign ram_wdata    = w_wdata;
  assign ram_we       = w_gnt_valid & w_we & ~w_oor;

  // Response register; RAM read data is sampled at the same edge that
  // commits the write, so a write returns the old word.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_rvalid  <= 1'b0;
      r_rid     <= '0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
      r_rerr    <= 1'b0;
    end else if (w_gnt_valid) begin
      r_rvalid  <= 1'b1;
      r_rid     <= w_gnt_idx;
      r_rdata_a <= w_oor ? '0 : ram_rdata_one;
      r_rdata_b <= w_oor ? '0 : ram_rdata_two;
      r_rerr    <= w_oor;
    end else begin
      r_rvalid  <= 1'b0;
    end
  end

  assign rvalid  = r_rvalid;
  assign rid     = r_rid;
  assign rdata_a = r_rdata_a;
  assign rdata_b = r_rdata_b;
  assign rerr    = r_rerr;

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_port_arbiter
// Purpose  : Self-checking bench for ram_port_arbiter: directed vector table,
//            hand-written lock/reset sequences and random traffic compared
//            against a behavioural model with its own memory image.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_port_arbiter;

  localparam int N = 16;
  localparam int M = 6000;
  localparam int K = 13;
  localparam int R = 4;

  logic           Clk = 1'b0;
  logic           Rst;
  logic [R-1:0]   req;
  logic [R-1:0]   we;
  logic [R-1:0]   lock;
  logic [R*K-1:0] addr_a_bus;
  logic [R*K-1:0] addr_b_bus;
  logic [R*N-1:0] wdata_bus;
  logic [R-1:0]   gnt;
  logic           rvalid;
  logic [1:0]     rid;
  logic [N-1:0]   rdata_a;
  logic [N-1:0]   rdata_b;
  logic           rerr;
  logic [K-1:0]   ram_addr_one;
  logic [K-1:0]   ram_addr_two;
  logic [K-1:0]   ram_addr_wr;
  logic           ram_we;
  logic [N-1:0]   ram_wdata;
  logic [N-1:0]   ram_rdata_one;
  logic [N-1:0]   ram_rdata_two;

  logic [K-1:0] aa [R];
  logic [K-1:0] ab [R];
  logic [N-1:0] wd [R];

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < R; g++) begin : g_pack
    assign addr_a_bus[g*K +: K] = aa[g];
    assign addr_b_bus[g*K +: K] = ab[g];
    assign wdata_bus[g*N +: N]  = wd[g];
  end

  ram_port_arbiter #(.N(N), .M(M), .K(K), .R(R)) dut (
    .Clk           (Clk),
    .Rst           (Rst),
    .req           (req),
    .we            (we),
    .lock          (lock),
    .addr_a        (addr_a_bus),
    .addr_b        (addr_b_bus),
    .wdata         (wdata_bus),
    .gnt           (gnt),
    .rvalid        (rvalid),
    .rid           (rid),
    .rdata_a       (rdata_a),
    .rdata_b       (rdata_b),
    .rerr          (rerr),
    .ram_addr_one  (ram_addr_one),
    .ram_addr_two  (ram_addr_two),
    .ram_addr_wr   (ram_addr_wr),
    .ram_we        (ram_we),
    .ram_wdata     (ram_wdata),
    .ram_rdata_one (ram_rdata_one),
    .ram_rdata_two (ram_rdata_two)
  );

  // RAM: combinational read, write at the rising edge.
  logic [N-1:0] mem [0:8191];
  logic         clear_mem;
  always @(posedge Clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 8192; i++) mem[i] <= '0;
    end else if (ram_we) begin
      mem[ram_addr_wr] <= ram_wdata;
    end
  end
  assign ram_rdata_one = mem[ram_addr_one];
  assign ram_rdata_two = mem[ram_addr_two];

  // ---------------- behavioural reference model ----------------
  int           m_ptr;
  bit           m_locked;
  int           m_owner;
  logic [N-1:0] ref_mem [0:8191];
  logic         e_rvalid;
  int           e_rid;
  logic [N-1:0] e_rda;
  logic [N-1:0] e_rdb;
  logic         e_rerr;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int m_winner();
    if (Rst) return -1;
    if (m_locked) return req[m_owner] ? m_owner : -1;
    for (int i = 0; i < R; i++) begin
      int j;
      j = (m_ptr + i) % R;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  function automatic bit m_oor(input int w);
    return (int'(aa[w]) >= M) || (int'(ab[w]) >= M);
  endfunction

  // One clock cycle: check combinational outputs mid-cycle, advance the
  // model at the edge, then check the registered response just after it.
  task automatic do_cycle(input logic rst_v, output logic [R-1:0] g, output logic rwe);
    int w;
    bit o;
    logic [R-1:0] eg;
    Rst = rst_v;
    #3;
    w  = m_winner();
    eg = (w >= 0) ? (4'b0001 << w) : 4'b0000;
    g   = gnt;
    rwe = ram_we;
    chk("gnt", 32'(gnt), 32'(eg));
    o = (w >= 0) ? m_oor(w) : 1'b0;
    chk("ram_we", 32'(ram_we), 32'((w >= 0) && we[w] && !o));
    if (w >= 0) begin
      chk("ram_addr_one", 32'(ram_addr_one), 32'(aa[w]));
      chk("ram_addr_two", 32'(ram_addr_two), 32'(ab[w]));
      chk("ram_addr_wr", 32'(ram_addr_wr), 32'(aa[w]));
      if (we[w]) chk("ram_wdata", 32'(ram_wdata), 32'(wd[w]));
    end else begin
      chk("ram_addr_idle", 32'(ram_addr_one), 32'd0);
    end
    @(posedge Clk);
    if (rst_v) begin
      m_ptr = 0; m_locked = 0; m_owner = 0;
      e_rvalid = 0; e_rid = 0; e_rda = '0; e_rdb = '0; e_rerr = 0;
    end else if (w >= 0) begin
      e_rvalid = 1;
      e_rid    = w;
      e_rda    = o ? '0 : ref_mem[aa[w]];
      e_rdb    = o ? '0 : ref_mem[ab[w]];
      e_rerr   = o;
      if (we[w] && !o) ref_mem[aa[w]] = wd[w];
      m_ptr = (w + 1) % R;
      if (!m_locked) begin
        if (lock[w]) begin m_locked = 1; m_owner = w; end
      end else if (!lock[w]) begin
        m_locked = 0;
      end
    end else begin
      e_rvalid = 0;
      m_locked = 0;   // a locked owner without request releases the lock
    end
    #1;
    chk("rvalid", 32'(rvalid), 32'(e_rvalid));
    chk("rid", 32'(rid), 32'(e_rid));
    chk("rdata_a", 32'(rdata_a), 32'(e_rda));
    chk("rdata_b", 32'(rdata_b), 32'(e_rdb));
    chk("rerr", 32'(rerr), 32'(e_rerr));
  endtask

  task automatic set_all(input logic [K-1:0] a, input logic [K-1:0] b, input logic [N-1:0] d);
    for (int i = 0; i < R; i++) begin aa[i] = a; ab[i] = b; wd[i] = d; end
  endtask

  task automatic do_reset();
    logic [R-1:0] g;
    logic rwe;
    req = '0; we = '0; lock = '0;
    do_cycle(1'b1, g, rwe);
    do_cycle(1'b1, g, rwe);
    Rst = 1'b0;
  endtask

  function automatic logic [K-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return 13'd5999;
    if (r == 1) return 13'd6000;
    if (r == 2) return 13'd8191;
    return K'($urandom_range(0, 15));
  endfunction

  typedef struct {
    logic [R-1:0] req, we;
    logic [K-1:0] aa, ab;
    logic [N-1:0] wd;
    logic [R-1:0] g;
    logic         rwe, rv;
    logic [1:0]   rid;
    logic [N-1:0] rda, rdb;
    logic         re;
  } vec_t;

  vec_t tbl [8];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [R-1:0] g;
    logic rwe;
    logic [R-1:0] last_g;
    logic [R-1:0] exp_lock [6];

    //          req      we       aa       ab       wd        g        rwe  rv   rid   rda       rdb       re
    tbl[0] = '{4'b0001, 4'b0001, 13'd5,    13'd0, 16'h1234, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h0000, 16'h0000, 1'b0};
    tbl[1] = '{4'b0001, 4'b0000, 13'd5,    13'd5, 16'h0000, 4'b0001, 1'b0, 1'b1, 2'd0, 16'h1234, 16'h1234, 1'b0};
    tbl[2] = '{4'b0010, 4'b0010, 13'd6000, 13'd5, 16'hFFFF, 4'b0010, 1'b0, 1'b1, 2'd1, 16'h0000, 16'h0000, 1'b1};
    tbl[3] = '{4'b0100, 4'b0000, 13'd5,    13'd5, 16'h0000, 4'b0100, 1'b0, 1'b1, 2'd2, 16'h1234, 16'h1234, 1'b0};
    tbl[4] = '{4'b1000, 4'b1000, 13'd7,    13'd0, 16'h1234, 4'b1000, 1'b1, 1'b1, 2'd3, 16'h0000, 16'h0000, 1'b0};
    tbl[5] = '{4'b0001, 4'b0001, 13'd7,    13'd7, 16'hBEEF, 4'b0001, 1'b1, 1'b1, 2'd0, 16'h1234, 16'h1234, 1'b0};
    tbl[6] = '{4'b0010, 4'b0000, 13'd7,    13'd7, 16'h0000, 4'b0010, 1'b0, 1'b1, 2'd1, 16'hBEEF, 16'hBEEF, 1'b0};
    tbl[7] = '{4'b0000, 4'b0000, 13'd0,    13'd0, 16'h0000, 4'b0000, 1'b0, 1'b0, 2'd1, 16'hBEEF, 16'hBEEF, 1'b0};

    for (int i = 0; i < 8192; i++) ref_mem[i] = '0;
    m_ptr = 0; m_locked = 0; m_owner = 0;
    e_rvalid = 0; e_rid = 0; e_rda = '0; e_rdb = '0; e_rerr = 0;
    clear_mem = 1'b1;
    set_all('0, '0, '0);
    Rst = 1'b1;
    do_reset();
    clear_mem = 1'b0;
    chk("reset_rvalid", 32'(rvalid), 32'd0);
    chk("reset_rdata_a", 32'(rdata_a), 32'd0);

    // Directed table
    for (int t = 0; t < 8; t++) begin
      req = tbl[t].req; we = tbl[t].we; lock = '0;
      set_all(tbl[t].aa, tbl[t].ab, tbl[t].wd);
      do_cycle(1'b0, g, rwe);
      chk("tbl_gnt", 32'(g), 32'(tbl[t].g));
      chk("tbl_ram_we", 32'(rwe), 32'(tbl[t].rwe));
      chk("tbl_rvalid", 32'(rvalid), 32'(tbl[t].rv));
      chk("tbl_rid", 32'(rid), 32'(tbl[t].rid));
      chk("tbl_rdata_a", 32'(rdata_a), 32'(tbl[t].rda));
      chk("tbl_rdata_b", 32'(rdata_b), 32'(tbl[t].rdb));
      chk("tbl_rerr", 32'(rerr), 32'(tbl[t].re));
    end

    // Round-robin rotation from a fresh pointer
    do_reset();
    req = 4'b1111; we = '0; lock = '0;
    for (int i = 0; i < R; i++) begin aa[i] = K'(i); ab[i] = K'(i + 1); wd[i] = '0; end
    for (int c = 0; c < 8; c++) begin
      do_cycle(1'b0, g, rwe);
      chk("rr_order", 32'(g), 32'(4'b0001 << (c % 4)));
      chk("rr_rvalid", 32'(rvalid), 32'd1);
    end

    // Requester 2 holds the RAM for three grants
    exp_lock = '{4'b0001, 4'b0010, 4'b0100, 4'b0100, 4'b0100, 4'b1000};
    do_reset();
    req = 4'b1111; we = '0; lock = 4'b0100;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) lock = '0;
      do_cycle(1'b0, g, rwe);
      chk("lock_seq", 32'(g), 32'(exp_lock[c]));
    end

    // Locked owner drops its request: idle cycle, then rotation resumes
    do_reset();
    req = 4'b1111; lock = 4'b0100;
    for (int c = 0; c < 3; c++) do_cycle(1'b0, g, rwe);
    req = 4'b1011;
    do_cycle(1'b0, g, rwe);
    chk("drop_idle_gnt", 32'(g), 32'd0);
    chk("drop_idle_rvalid", 32'(rvalid), 32'd0);
    do_cycle(1'b0, g, rwe);
    chk("drop_next_gnt", 32'(g), 32'(4'b1000));

    // Reset during a locked burst with a write pending
    do_reset();
    req = 4'b1111; we = '0; lock = 4'b0100;
    set_all(13'd9, 13'd9, 16'hDEAD);
    for (int c = 0; c < 3; c++) do_cycle(1'b0, g, rwe);
    we = 4'b1111;
    do_cycle(1'b1, g, rwe);
    chk("rst_lock_gnt", 32'(g), 32'd0);
    chk("rst_lock_we", 32'(rwe), 32'd0);
    chk("rst_lock_rvalid", 32'(rvalid), 32'd0);
    we = '0; lock = '0;
    do_cycle(1'b0, g, rwe);
    chk("rst_after_gnt", 32'(g), 32'(4'b0001));
    chk("rst_no_write", 32'(rdata_a), 32'd0);

    // Random traffic; a pending requester keeps its fields stable
    do_reset();
    last_g = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < R; i++) begin
        if (!(req[i] && !last_g[i])) begin
          req[i]  = ($urandom_range(0, 99) < 60);
          we[i]   = 1'($urandom_range(0, 1));
          lock[i] = ($urandom_range(0, 99) < 20);
          aa[i]   = pick_addr();
          ab[i]   = pick_addr();
          wd[i]   = N'($urandom);
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        do_cycle(1'b1, g, rwe);
        Rst = 1'b0;
        last_g = '0;
      end else begin
        do_cycle(1'b0, g, rwe);
        last_g = g;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Round-robin arbiter that shares the dual-read/single-write state RAM between `R` requesters (ODE stage units, loader, result reader). Each granted transaction is a one-cycle RAM access: two operand reads, plus an optional write to the first operand address. Read data is registered back to the winner one cycle later. A lock lets one requester hold the RAM for back-to-back accesses, e.g. a read-modify-write sequence.

## Interface
Parameters:
- `N`, 16, data width
- `M`, 6000, RAM depth in words
- `K`, 13, address width
- `R`, 4, number of requesters (2..8)

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge
- `Rst`  in  1  reset, synchronous, active-high
- `req`  in  R  request per requester; held until granted
- `we`  in  R  request is a write
- `lock`  in  R  keep ownership after this grant
- `addr_a`  in  R*K  packed per requester; read port one and write address
- `addr_b`  in  R*K  packed per requester; read port two
- `wdata`  in  R*N  packed per requester write data
- `gnt`  out  R  one-hot, combinational; transaction accepted at this edge
- `rvalid`  out  1  response valid, registered
- `rid`  out  clog2(R)  requester index of the response
- `rdata_a`, `rdata_b`  out  N each  read data of the response
- `rerr`  out  1  response had an out-of-range address
- `ram_addr_one`, `ram_addr_two`, `ram_addr_wr`  out  K each  to RAM
- `ram_we`  out  1  to RAM
- `ram_wdata`  out  N  to RAM
- `ram_rdata_one`, `ram_rdata_two`  in  N each  from RAM (combinational read)

## Operation
- Winner selection in each cycle:
  - LOCKED state: the owner is the sole candidate.
  - UNLOCKED state: the first `req` bit at or after `ptr`, wrapping modulo `R`.
- `gnt[w]`=1 only when `req[w]`=1, `Rst`=0 and a winner exists. At most one `gnt` bit is high.
- RAM port driving:
  - `ram_addr_one`=`addr_a[w]`, `ram_addr_wr`=`addr_a[w]`, `ram_addr_two`=`addr_b[w]`, `ram_wdata`=`wdata[w]`.
  - With no winner, RAM addresses hold the value 0.
- `ram_we`=`gnt[w]` & `we[w]` & in-range. Out-of-range means `addr_a`>=M or `addr_b`>=M; such a write is suppressed.
- Response, registered at the edge ending the grant cycle:
  - `rvalid`<=1, `rid`<=w, `rdata_a`/`rdata_b`<=`ram_rdata_one`/`ram_rdata_two`.
  - `rerr`<=out-of-range.
  - An out-of-range read returns data 0.
  - With no grant, `rvalid`<=0 and the data registers hold their values.
- Writes are read-before-write: `rdata_a` of a write returns the old contents.
- Pointer: after any grant to w, `ptr`<=(w+1) mod R.
- Lock FSM:
  - UNLOCKED -> LOCKED(owner=w) on a grant with `lock[w]`=1.
  - LOCKED -> UNLOCKED on a grant to the owner with `lock`=0, or in any cycle where `req[owner]`=0.
  - LOCKED with `req[owner]`=0 grants nothing that cycle; the release takes effect next cycle.
- Reset values:
  - `ptr`=0, state UNLOCKED, `rvalid`=0, `rid`=0, `rdata_a`=0, `rdata_b`=0, `rerr`=0.
  - While `Rst`=1: `gnt`=0 and `ram_we`=0, so no RAM write occurs at a reset edge.

## Timing
- Grant latency: 0 cycles when uncontested (`req` rising in cycle t gives `gnt` in cycle t).
- Response latency: 1 cycle; `rvalid` is high in cycle t+1 for a grant in cycle t.
- Throughput: one transaction per cycle. A locked owner gets back-to-back grants.
- Worst-case wait for an unlocked requester: R-1 grants, plus the duration of any lock held by another requester.
- Reset asserted mid-lock or mid-response: at the next edge the block returns to reset values. A pending response is dropped, and requesters re-issue.
- Requesters must not change `we`/`addr`/`wdata` while `req`=1 and `gnt`=0.

## Structure
- Package `ram_ctrl_pkg`:
  - Lock state enum UNLOCKED/LOCKED.
  - `IDXW` = clog2(R).
  - Helper function for packed-slice extraction of per-requester fields.
- Sub-module `ram_rr_arbiter`: `req`/`lock` in, `gnt`/index out, holding `ptr` and the lock FSM.
- Top level: field muxing, range check, RAM drive and the response register.

## Test plan
- After reset: `rvalid`=0, `gnt`=0. Then `req`=0b0001, `we`=1, addr_a=5, wdata=0x1234 -> `gnt`=0b0001, `ram_we`=1. Next: `req`=0b0001, `we`=0, addr_a=5 -> next cycle `rvalid`=1, `rid`=0, `rdata_a`=0x1234.
- `req`=0b1111 held for 8 cycles -> grant order 0,1,2,3,0,1,2,3; `rvalid` high in every cycle 1..8.
- Requester 2 locks for 3 grants while `req`=0b1111 -> `gnt`=0b0100 three times, then requester 3 is granted.
- Write with addr_a=6000 -> `ram_we`=0, response `rerr`=1, `rdata_a`=0; the RAM word at address 5 is unchanged.
- Write 0xBEEF over 0x1234 at addr 7, reading addr_b=7 in the same transaction -> `rdata_a`=`rdata_b`=0x1234; a following read returns 0xBEEF.
- `Rst` asserted during a locked burst with `req` active -> `gnt`=0 and no write that cycle. The following cycle: `rvalid`=0, `ptr`=0, and requester 0 wins if requesting.
